// File: rtl/idiv_seq.sv
// Sequential restoring radix-2 unsigned divider: one quotient bit per clock,
// start/done handshake, divide-by-zero flagged with a saturated quotient.
module idiv_seq #(
  parameter int SIZE = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            iStart,
  input  logic [SIZE-1:0] iDividend,
  input  logic [SIZE-1:0] iDivisor,
  output logic            oBusy,
  output logic            oDone,
  output logic [SIZE-1:0] oQuotient,
  output logic [SIZE-1:0] oRemainder,
  output logic            oDivByZero
);

  localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SIZE-1:0]   dividend_q, dividend_d;
  logic [SIZE-1:0]   divisor_q, divisor_d;
  logic [SIZE-1:0]   rem_q, rem_d;
  logic [SIZE-1:0]   quo_q, quo_d;
  logic [SIZE-1:0]   resQ_q, resQ_d;
  logic [SIZE-1:0]   resR_q, resR_d;
  logic              dz_q, dz_d;

  // R' needs one extra bit: the shifted-in remainder can exceed the divisor width.
  logic [SIZE:0]     rShift;
  logic [SIZE-1:0]   rDiff;
  logic              fits;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      resQ_q     <= '0;
      resR_q     <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      resQ_q     <= resQ_d;
      resR_q     <= resR_d;
      dz_q       <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    resQ_d     = resQ_q;
    resR_d     = resR_q;
    dz_d       = dz_q;

    rShift = {rem_q, dividend_q[SIZE-1]};
    fits   = (rShift >= {1'b0, divisor_q});
    // Result is below the divisor when it is taken, so the low bits suffice.
    rDiff  = rShift[SIZE-1:0] - divisor_q;

    case (state_q)
      IDLE: begin
        if (iStart) begin
          dividend_d = iDividend;
          divisor_d  = iDivisor;
          dz_d       = 1'b0;
          if (iDivisor == '0) begin
            state_d = DONE;
            resQ_d  = '1;
            resR_d  = iDividend;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
            count_d = CW'(SIZE - 1);
            rem_d   = '0;
            quo_d   = '0;
          end
        end
      end
      CALC: begin
        rem_d      = fits ? rDiff : rShift[SIZE-1:0];
        quo_d      = {quo_q[SIZE-2:0], fits};
        dividend_d = {dividend_q[SIZE-2:0], 1'b0};
        if (count_q == '0) begin
          state_d = DONE;
          resQ_d  = quo_d;
          resR_d  = rem_d;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign oBusy      = (state_q != IDLE);
  assign oDone      = (state_q == DONE);
  assign oQuotient  = resQ_q;
  assign oRemainder = resR_q;
  assign oDivByZero = dz_q;

endmodule

// File: tb/tb_idiv_seq.sv
// Self-checking bench for idiv_seq: arithmetic reference model compared every
// cycle, directed literal cases, random traffic, and an exhaustive 4-bit sweep.
module tb_idiv_seq;

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic [15:0] iDividend;
  logic [15:0] iDivisor;
  logic        oBusy;
  logic        oDone;
  logic [15:0] oQuotient;
  logic [15:0] oRemainder;
  logic        oDivByZero;

  logic        s4Start;
  logic [3:0]  s4A;
  logic [3:0]  s4D;
  logic        s4Busy;
  logic        s4Done;
  logic [3:0]  s4Q;
  logic [3:0]  s4R;
  logic        s4Dz;

  int checks = 0;
  int errors = 0;

  idiv_seq #(.SIZE(16)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iStart     (iStart),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oDivByZero (oDivByZero)
  );

  idiv_seq #(.SIZE(4)) dut4 (
    .Clock      (Clock),
    .Reset      (Reset),
    .iStart     (s4Start),
    .iDividend  (s4A),
    .iDivisor   (s4D),
    .oBusy      (s4Busy),
    .oDone      (s4Done),
    .oQuotient  (s4Q),
    .oRemainder (s4R),
    .oDivByZero (s4Dz)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: latency and results from plain arithmetic.
  logic [15:0] mQ, mR, pendQ, pendR;
  logic        mDone, mDz, prevDone;
  int          mLeft;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mQ = '0; mR = '0; mDone = 1'b0; mDz = 1'b0; mLeft = 0;
      pendQ = '0; pendR = '0;
    end else begin
      prevDone = mDone;
      mDone = 1'b0;
      if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) begin
          mDone = 1'b1;
          mQ = pendQ;
          mR = pendR;
        end
      end else if (!prevDone && iStart) begin
        mDz = 1'b0;
        if (iDivisor == 16'd0) begin
          mDone = 1'b1;
          mQ = 16'hFFFF;
          mR = iDividend;
          mDz = 1'b1;
        end else begin
          mLeft = 16;
          pendQ = iDividend / iDivisor;
          pendR = iDividend % iDivisor;
        end
      end
    end
  end

  always @(negedge Clock) begin
    checkOutput("busy", 32'(oBusy), 32'((mLeft > 0) || mDone));
    checkOutput("done", 32'(oDone), 32'(mDone));
    checkOutput("quotient", 32'(oQuotient), 32'(mQ));
    checkOutput("remainder", 32'(oRemainder), 32'(mR));
    checkOutput("divByZero", 32'(oDivByZero), 32'(mDz));
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d);
    int guard;
    @(negedge Clock);
    guard = 0;
    while (oBusy && guard < 50) begin
      @(negedge Clock);
      guard++;
    end
    if (oBusy) checkOutput("idleTimeout", 32'(oBusy), 32'd0);
    iDividend = a;
    iDivisor  = d;
    iStart    = 1'b1;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
  endtask

  task automatic waitDone(input bit stray, output int n);
    n = 1;
    while (!oDone && n < 40) begin
      if (stray && $urandom_range(0, 5) == 0) begin
        iStart    = 1'b1;
        iDividend = 16'($urandom);
        iDivisor  = 16'($urandom);
      end else begin
        iStart = 1'b0;
      end
      @(posedge Clock);
      #1;
      n++;
    end
    iStart = 1'b0;
    if (!oDone) checkOutput("doneTimeout", 32'(oDone), 32'd1);
  endtask

  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] d,
                          input int expEdges, input logic [15:0] expQ, input logic [15:0] expR,
                          input logic expDz);
    int n;
    applyStimulus(a, d);
    waitDone(1'b0, n);
    checkOutput({name, "_edges"}, 32'(n), 32'(expEdges));
    checkOutput({name, "_q"}, 32'(oQuotient), 32'(expQ));
    checkOutput({name, "_r"}, 32'(oRemainder), 32'(expR));
    checkOutput({name, "_dz"}, 32'(oDivByZero), 32'(expDz));
  endtask

  initial begin
    int n;
    int guard;
    logic [15:0] ra, rd;

    Reset = 1'b1; iStart = 1'b0; iDividend = '0; iDivisor = '0;
    s4Start = 1'b0; s4A = '0; s4D = '0;
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("rst_busy", 32'(oBusy), 32'd0);
    checkOutput("rst_done", 32'(oDone), 32'd0);
    checkOutput("rst_q", 32'(oQuotient), 32'd0);
    checkOutput("rst_r", 32'(oRemainder), 32'd0);
    checkOutput("rst_dz", 32'(oDivByZero), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    directed("t1_100div7", 16'd100, 16'd7, 17, 16'd14, 16'd2, 1'b0);
    @(posedge Clock);
    #1;
    checkOutput("t1_busyAfter", 32'(oBusy), 32'd0);

    directed("t2_ffffdiv1", 16'hFFFF, 16'd1, 17, 16'hFFFF, 16'd0, 1'b0);
    directed("t2_3div9", 16'd3, 16'd9, 17, 16'd0, 16'd3, 1'b0);

    directed("t3_divzero", 16'h1234, 16'd0, 1, 16'hFFFF, 16'h1234, 1'b1);
    directed("t3_10div5", 16'd10, 16'd5, 17, 16'd2, 16'd0, 1'b0);

    applyStimulus(16'd1000, 16'd3);
    repeat (3) @(posedge Clock);
    #1;
    iDividend = 16'd50; iDivisor = 16'd5; iStart = 1'b1;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    waitDone(1'b0, n);
    checkOutput("t4_q", 32'(oQuotient), 32'd333);
    checkOutput("t4_r", 32'(oRemainder), 32'd1);

    applyStimulus(16'd60000, 16'd7);
    repeat (7) @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    checkOutput("t5_busy", 32'(oBusy), 32'd0);
    checkOutput("t5_done", 32'(oDone), 32'd0);
    checkOutput("t5_q", 32'(oQuotient), 32'd0);
    checkOutput("t5_r", 32'(oRemainder), 32'd0);
    checkOutput("t5_dz", 32'(oDivByZero), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (20) begin
      @(negedge Clock);
      checkOutput("t5_noDone", 32'(oDone), 32'd0);
    end
    directed("t5_9div2", 16'd9, 16'd2, 17, 16'd4, 16'd1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       rd = 16'd0;
        1, 2:    rd = 16'($urandom_range(1, 15));
        3:       rd = ra;
        default: rd = 16'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge Clock);
      applyStimulus(ra, rd);
      waitDone(1'b1, n);
      checkOutput("rnd_latency", 32'(n), (rd == 16'd0) ? 32'd1 : 32'd17);
    end

    $display("[TB] exhaustive 4-bit sweep");
    for (int a = 0; a < 16; a++) begin
      for (int d = 0; d < 16; d++) begin
        @(negedge Clock);
        guard = 0;
        while (s4Busy && guard < 20) begin
          @(negedge Clock);
          guard++;
        end
        s4A = 4'(a);
        s4D = 4'(d);
        s4Start = 1'b1;
        @(posedge Clock);
        #1;
        s4Start = 1'b0;
        n = 1;
        while (!s4Done && n < 12) begin
          @(posedge Clock);
          #1;
          n++;
        end
        if (d == 0) begin
          checkOutput("s4_zeroEdges", 32'(n), 32'd1);
          checkOutput("s4_zeroQ", 32'(s4Q), 32'd15);
          checkOutput("s4_zeroR", 32'(s4R), 32'(a));
          checkOutput("s4_zeroDz", 32'(s4Dz), 32'd1);
        end else begin
          checkOutput("s4_edges", 32'(n), 32'd5);
          checkOutput("s4_identity", 32'(s4Q) * 32'(d) + 32'(s4R), 32'(a));
          checkOutput("s4_rLtD", 32'(int'(s4R) < d), 32'd1);
          checkOutput("s4_q", 32'(s4Q), 32'(a / d));
          checkOutput("s4_dz", 32'(s4Dz), 32'd0);
        end
      end
    end

    repeat (3) @(negedge Clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
